c16_rom_bank_ctrl: RTL and testbench

//  Parametrised ROM banking, reset sequencing and ROM-download arbitration for the C16 motherboard.

---
 rtl/c16_rom_bank_ctrl_if.sv | 37 +++
 rtl/c16_rom_bank_ctrl.sv | 150 +++++++++++++++
 tb/tb_c16_rom_bank_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c16_rom_bank_ctrl_if.sv
// c16_rom_bank_ctrl_if
//   Bundles the CPU/TED bus, the ROM loader handshake and the ROM array side
//   of the C16 ROM banking controller.
//   master : CPU bus + loader driver (CPU_EN, ADDR, RW, CS0, CS1, DL_*),
//            observes DL_ACK and the ROM_* outputs.
//   slave  : the controller; the mirror image of master.
//   SELW   : bank select bits per half; ADDR_W : ROM array address width.
interface c16_rom_bank_ctrl_if #(
  parameter int SELW   = 2,
  parameter int ADDR_W = 14
);
  logic                  CPU_EN;
  logic [15:0]           ADDR;
  logic                  RW;
  logic                  CS0;
  logic                  CS1;
  logic                  DL_REQ;
  logic [SELW:0]         DL_SLOT;
  logic [ADDR_W-1:0]     DL_ADDR;
  logic [7:0]            DL_DATA;
  logic                  DL_ACK;
  logic [2*SELW-1:0]     ROM_SEL;
  logic [ADDR_W-1:0]     ROM_ADDR;
  logic                  ROM_WE;
  logic [SELW:0]         ROM_WSLOT;
  logic [7:0]            ROM_WDATA;

  modport master (
    output CPU_EN, ADDR, RW, CS0, CS1, DL_REQ, DL_SLOT, DL_ADDR, DL_DATA,
    input  DL_ACK, ROM_SEL, ROM_ADDR, ROM_WE, ROM_WSLOT, ROM_WDATA
  );

  modport slave (
    input  CPU_EN, ADDR, RW, CS0, CS1, DL_REQ, DL_SLOT, DL_ADDR, DL_DATA,
    output DL_ACK, ROM_SEL, ROM_ADDR, ROM_WE, ROM_WSLOT, ROM_WDATA
  );
endinterface

// File: rtl/c16_rom_bank_ctrl.sv
// c16_rom_bank_ctrl
//   ROM banking, soft-reset sequencing and ROM-download arbitration for the
//   C16 motherboard, between the CPU/TED bus and the internal ROM arrays.
//   Ports:
//     CLK28    : 28 MHz system clock
//     RESET    : asynchronous active-high reset
//     KEYRESET : synchronous reset request (CTRL+ALT+DEL)
//     SRESET   : system soft reset, held RST_CYCLES+1 cycles after the last
//                reset source drops
//     bus      : slave side of c16_rom_bank_ctrl_if (CPU bus, loader
//                handshake DL_*, ROM array controls ROM_*)
module c16_rom_bank_ctrl #(
  parameter int          SELW        = 2,
  parameter int          ADDR_W      = 14,
  parameter logic [15:0] BANK_BASE   = 16'hFDD0,
  parameter logic [7:0]  KERNAL_PAGE = 8'hFC,
  parameter logic [23:0] RST_CYCLES  = 24'hFFFFFF
) (
  input  logic                CLK28,
  input  logic                RESET,
  input  logic                KEYRESET,
  output logic                SRESET,
  c16_rom_bank_ctrl_if.slave  bus
);

  localparam int BW = 2 * SELW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_ACK
  } dl_state_t;

  logic [23:0]     rst_count;
  logic [BW-1:0]   bank_reg;
  logic            bank_hit;
  logic            kernal_hit;
  logic            cs_free;
  dl_state_t       dl_state;
  logic            rom_we_q;
  logic            dl_ack_q;
  logic [SELW:0]   wslot_q;
  logic [7:0]      wdata_q;

  assign bank_hit   = (bus.ADDR[15:BW] == BANK_BASE[15:BW]);
  assign kernal_hit = (bus.ADDR[15:8] == KERNAL_PAGE);
  assign cs_free    = bus.CS0 & bus.CS1;

  // Soft-reset sequencer: any reset source restarts the count from zero and
  // holds SRESET high; once the count reaches RST_CYCLES it freezes and
  // SRESET drops one cycle later.
  always_ff @(posedge CLK28 or posedge RESET) begin
    if (RESET) begin
      rst_count <= '0;
      SRESET    <= 1'b1;
    end else if (KEYRESET) begin
      rst_count <= '0;
      SRESET    <= 1'b1;
    end else if (rst_count < RST_CYCLES) begin
      rst_count <= rst_count + 24'd1;
      SRESET    <= 1'b1;
    end else begin
      SRESET    <= 1'b0;
    end
  end

  // Bank register: the written value comes from the low address bits, not the
  // data bus. Only the CPU_EN strobe qualifies the write so a stretched bus
  // cycle updates it once. Soft reset wins over a simultaneous write.
  always_ff @(posedge CLK28 or posedge RESET) begin
    if (RESET) begin
      bank_reg <= '0;
    end else if (SRESET) begin
      bank_reg <= '0;
    end else if (bus.CPU_EN && !bus.RW && bank_hit) begin
      bank_reg <= bus.ADDR[BW-1:0];
    end
  end

  // The kernal page always sees high slot 0 regardless of the bank register.
  assign bus.ROM_SEL = {(kernal_hit ? {SELW{1'b0}} : bank_reg[BW-1:SELW]),
                        bank_reg[SELW-1:0]};

  // The loader owns the ROM address lines only during its single write cycle.
  assign bus.ROM_ADDR = (dl_state == ST_WRITE) ? bus.DL_ADDR
                                               : bus.ADDR[ADDR_W-1:0];

  // Download handshake: a request waits until neither ROM half is selected by
  // the CPU, performs exactly one write cycle, then acknowledges until the
  // loader drops its request. Dropping the request while waiting abandons the
  // byte. Slot and data are captured on entry to the write so the loader may
  // change them afterwards.
  always_ff @(posedge CLK28 or posedge RESET) begin
    if (RESET) begin
      dl_state <= ST_IDLE;
      rom_we_q <= 1'b0;
      dl_ack_q <= 1'b0;
      wslot_q  <= '0;
      wdata_q  <= '0;
    end else begin
      case (dl_state)
        ST_IDLE: begin
          if (bus.DL_REQ) begin
            if (cs_free) begin
              dl_state <= ST_WRITE;
              rom_we_q <= 1'b1;
              wslot_q  <= bus.DL_SLOT;
              wdata_q  <= bus.DL_DATA;
            end else begin
              dl_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!bus.DL_REQ) begin
            dl_state <= ST_IDLE;
          end else if (cs_free) begin
            dl_state <= ST_WRITE;
            rom_we_q <= 1'b1;
            wslot_q  <= bus.DL_SLOT;
            wdata_q  <= bus.DL_DATA;
          end
        end
        ST_WRITE: begin
          dl_state <= ST_ACK;
          rom_we_q <= 1'b0;
          dl_ack_q <= 1'b1;
        end
        ST_ACK: begin
          if (!bus.DL_REQ) begin
            dl_state <= ST_IDLE;
            dl_ack_q <= 1'b0;
          end
        end
        default: begin
          dl_state <= ST_IDLE;
          rom_we_q <= 1'b0;
          dl_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ROM_WE    = rom_we_q;
  assign bus.DL_ACK    = dl_ack_q;
  assign bus.ROM_WSLOT = wslot_q;
  assign bus.ROM_WDATA = wdata_q;

endmodule

// File: tb/tb_c16_rom_bank_ctrl.sv
// tb_c16_rom_bank_ctrl
//   Self-checking bench for c16_rom_bank_ctrl with SELW=2, ADDR_W=14 and a
//   short soft-reset count of 16 cycles. Inputs change 2 time units after a
//   rising clock edge; outputs are compared at the same point.
module tb_c16_rom_bank_ctrl;

  localparam int RST = 16;

  logic CLK28;
  logic RESET;
  logic KEYRESET;
  logic SRESET;

  int vecCount  = 0;
  int missCount = 0;

  c16_rom_bank_ctrl_if #(.SELW(2), .ADDR_W(14)) bus ();

  c16_rom_bank_ctrl #(
    .SELW        (2),
    .ADDR_W      (14),
    .BANK_BASE   (16'hFDD0),
    .KERNAL_PAGE (8'hFC),
    .RST_CYCLES  (24'd16)
  ) dut (
    .CLK28    (CLK28),
    .RESET    (RESET),
    .KEYRESET (KEYRESET),
    .SRESET   (SRESET),
    .bus      (bus)
  );

  // 28 MHz-ish clock; the exact period is irrelevant to the logic.
  initial CLK28 = 1'b0;
  always #5 CLK28 = ~CLK28;

  // Reference model: tracks how many edges have passed since a reset source
  // was last seen, and what the bank register should hold. SRESET is expected
  // high while that distance is at most RST.
  int         mdlSince = 0;
  logic [3:0] mdlBank  = 4'h0;

  always @(posedge CLK28 or posedge RESET) begin
    if (RESET) begin
      mdlSince <= 0;
      mdlBank  <= 4'h0;
    end else begin
      if (KEYRESET)
        mdlSince <= 0;
      else if (mdlSince <= RST)
        mdlSince <= mdlSince + 1;
      if (mdlSince <= RST)
        mdlBank <= 4'h0;
      else if (bus.CPU_EN && !bus.RW && ((bus.ADDR >> 4) == 16'h0FDD))
        mdlBank <= bus.ADDR[3:0];
    end
  end

  function automatic logic [3:0] mdlSel(input logic [15:0] addr, input logic [3:0] bank);
    logic [1:0] hi;
    hi = ((addr >> 8) == 16'h00FC) ? 2'b00 : bank[3:2];
    return {hi, bank[1:0]};
  endfunction

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, vectors=%0d", vecCount);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK28);
    #2;
  endtask

  task automatic applyStimulus(input logic cpuEn, input logic rw, input logic [15:0] addr);
    bus.CPU_EN = cpuEn;
    bus.RW     = rw;
    bus.ADDR   = addr;
  endtask

  // One complete loader byte. While busy>0 one chip select is held low; it is
  // released when busy counts down. The write must appear on the first edge
  // that sees the request with both selects high, and the ack on the next.
  task automatic doXfer(input logic [2:0] slot, input logic [13:0] addr,
                        input logic [7:0] data, input int busyIn,
                        input bit useCs1, input string tag);
    int busy;
    int writes;
    int freeEdge;
    int weEdge;
    int ackEdge;
    bit freeNow;
    busy     = busyIn;
    writes   = 0;
    freeEdge = -1;
    weEdge   = -1;
    ackEdge  = -1;
    bus.DL_SLOT = slot;
    bus.DL_ADDR = addr;
    bus.DL_DATA = data;
    bus.DL_REQ  = 1'b1;
    bus.CS0     = (busy > 0 && !useCs1) ? 1'b0 : 1'b1;
    bus.CS1     = (busy > 0 &&  useCs1) ? 1'b0 : 1'b1;
    for (int c = 0; c < 40 && ackEdge < 0; c++) begin
      freeNow = bus.CS0 && bus.CS1;
      step();
      if (freeNow && freeEdge < 0) freeEdge = c;
      if (bus.ROM_WE === 1'b1) begin
        writes++;
        weEdge = c;
        checkOutput({tag, "_romaddr"}, 32'(bus.ROM_ADDR), 32'(addr));
        checkOutput({tag, "_wslot"}, 32'(bus.ROM_WSLOT), 32'(slot));
        checkOutput({tag, "_wdata"}, 32'(bus.ROM_WDATA), 32'(data));
      end
      if (bus.DL_ACK === 1'b1) ackEdge = c;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          bus.CS0 = 1'b1;
          bus.CS1 = 1'b1;
        end
      end
    end
    checkOutput({tag, "_writes"}, 32'(writes), 32'd1);
    checkOutput({tag, "_we_latency"}, 32'(weEdge), 32'(freeEdge));
    checkOutput({tag, "_ack_after_we"}, 32'(ackEdge), 32'(weEdge + 1));
    step();
    checkOutput({tag, "_ack_held"}, 32'(bus.DL_ACK), 32'd1);
    checkOutput({tag, "_we_after"}, 32'(bus.ROM_WE), 32'd0);
    bus.DL_REQ = 1'b0;
    step();
    checkOutput({tag, "_ack_drop"}, 32'(bus.DL_ACK), 32'd0);
  endtask

  typedef struct {
    logic        cpuEn;
    logic        rw;
    logic [15:0] addr;
    logic [3:0]  expSel;
    logic [13:0] expRomAddr;
  } vec_t;

  vec_t vecs [13];

  initial begin
    // Banking / kernal-window vectors, applied in order from bank reg = 0.
    vecs[0]  = '{1'b1, 1'b0, 16'hFDD6, 4'b0110, 14'h3DD6};
    vecs[1]  = '{1'b0, 1'b0, 16'hFDD9, 4'b0110, 14'h3DD9};
    vecs[2]  = '{1'b0, 1'b1, 16'hE010, 4'b0110, 14'h2010};
    vecs[3]  = '{1'b1, 1'b0, 16'hFDE0, 4'b0110, 14'h3DE0};
    vecs[4]  = '{1'b1, 1'b1, 16'hFDDB, 4'b0110, 14'h3DDB};
    vecs[5]  = '{1'b1, 1'b0, 16'hFDDB, 4'b1011, 14'h3DDB};
    vecs[6]  = '{1'b0, 1'b1, 16'hFC10, 4'b0011, 14'h3C10};
    vecs[7]  = '{1'b0, 1'b1, 16'hE010, 4'b1011, 14'h2010};
    vecs[8]  = '{1'b0, 1'b1, 16'hFCFF, 4'b0011, 14'h3CFF};
    vecs[9]  = '{1'b0, 1'b1, 16'hFB00, 4'b1011, 14'h3B00};
    vecs[10] = '{1'b1, 1'b0, 16'hFDDF, 4'b1111, 14'h3DDF};
    vecs[11] = '{1'b0, 1'b1, 16'hFC00, 4'b0011, 14'h3C00};
    vecs[12] = '{1'b1, 1'b0, 16'hFCD0, 4'b0011, 14'h3CD0};

    RESET       = 1'b1;
    KEYRESET    = 1'b0;
    bus.CPU_EN  = 1'b0;
    bus.RW      = 1'b1;
    bus.ADDR    = 16'hE000;
    bus.CS0     = 1'b1;
    bus.CS1     = 1'b1;
    bus.DL_REQ  = 1'b0;
    bus.DL_SLOT = '0;
    bus.DL_ADDR = '0;
    bus.DL_DATA = '0;

    // Reset state.
    repeat (3) step();
    checkOutput("rst_sreset", 32'(SRESET), 32'd1);
    checkOutput("rst_romsel", 32'(bus.ROM_SEL), 32'd0);
    checkOutput("rst_romwe", 32'(bus.ROM_WE), 32'd0);
    checkOutput("rst_dlack", 32'(bus.DL_ACK), 32'd0);
    checkOutput("rst_romaddr", 32'(bus.ROM_ADDR), 32'h2000);

    // Soft-reset length after RESET release: high through edge 16, low at 17.
    RESET = 1'b0;
    repeat (RST) step();
    checkOutput("sreset_edge16", 32'(SRESET), 32'd1);
    step();
    checkOutput("sreset_edge17", 32'(SRESET), 32'd0);

    // KEYRESET eight cycles into a count restarts it.
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    repeat (8) step();
    KEYRESET = 1'b1;
    step();
    KEYRESET = 1'b0;
    checkOutput("key_sreset_on", 32'(SRESET), 32'd1);
    repeat (RST) step();
    checkOutput("key_sreset_edge16", 32'(SRESET), 32'd1);
    step();
    checkOutput("key_sreset_edge17", 32'(SRESET), 32'd0);

    // Table-driven banking and kernal window.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].cpuEn, vecs[i].rw, vecs[i].addr);
      step();
      checkOutput($sformatf("tbl%0d_romsel", i), 32'(bus.ROM_SEL), 32'(vecs[i].expSel));
      checkOutput($sformatf("tbl%0d_romaddr", i), 32'(bus.ROM_ADDR), 32'(vecs[i].expRomAddr));
    end

    // Stretched write: CPU_EN on the first of five cycles only.
    applyStimulus(1'b1, 1'b0, 16'hFDD6);
    step();
    applyStimulus(1'b0, 1'b0, 16'hFDD6);
    repeat (4) step();
    checkOutput("stretch_romsel", 32'(bus.ROM_SEL), 32'b0110);
    applyStimulus(1'b0, 1'b0, 16'hFDD9);
    repeat (5) step();
    checkOutput("noen_romsel", 32'(bus.ROM_SEL), 32'b0110);
    applyStimulus(1'b0, 1'b1, 16'hE000);
    step();

    // Randomised CPU bus traffic with occasional KEYRESET against the model.
    for (int i = 0; i < 1500; i++) begin
      int kind;
      logic [15:0] a;
      kind = $urandom_range(0, 5);
      if (kind < 2)       a = {12'hFDD, 4'($urandom_range(0, 15))};
      else if (kind == 2) a = {8'hFC, 8'($urandom)};
      else if (kind == 3) a = {12'hFDE, 4'($urandom_range(0, 15))};
      else                a = 16'($urandom);
      applyStimulus(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), a);
      KEYRESET = ($urandom_range(0, 199) == 0);
      bus.CS0  = 1'($urandom_range(0, 1));
      bus.CS1  = 1'($urandom_range(0, 1));
      step();
      checkOutput($sformatf("rnd%0d_sreset", i), 32'(SRESET), 32'(mdlSince <= RST));
      checkOutput($sformatf("rnd%0d_romsel", i), 32'(bus.ROM_SEL), 32'(mdlSel(bus.ADDR, mdlBank)));
      checkOutput($sformatf("rnd%0d_romaddr", i), 32'(bus.ROM_ADDR), 32'(bus.ADDR & 16'h3FFF));
      checkOutput($sformatf("rnd%0d_romwe", i), 32'(bus.ROM_WE), 32'd0);
    end
    KEYRESET = 1'b0;
    bus.CS0  = 1'b1;
    bus.CS1  = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'hE000);
    step();

    // Plain handshake, then one blocked by CS1 for two cycles.
    doXfer(3'b100, 14'h1234, 8'hA5, 0, 1'b1, "hs_basic");
    doXfer(3'b011, 14'h0ABC, 8'h5A, 2, 1'b1, "hs_cs1busy");

    // Randomised loader traffic with random CPU addresses and contention.
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b1, 16'($urandom));
      doXfer(3'($urandom), 14'($urandom), 8'($urandom), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), $sformatf("hs_rnd%0d", i));
    end
    applyStimulus(1'b0, 1'b1, 16'hE010);

    // Abort: request dropped while waiting for CS1.
    bus.DL_REQ = 1'b1;
    bus.CS1    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("abort_wait%0d_we", i), 32'(bus.ROM_WE), 32'd0);
    end
    bus.DL_REQ = 1'b0;
    step();
    bus.CS1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("abort_after%0d_we", i), 32'(bus.ROM_WE), 32'd0);
      checkOutput($sformatf("abort_after%0d_ack", i), 32'(bus.DL_ACK), 32'd0);
    end

    // Reset in the middle of a transfer.
    applyStimulus(1'b1, 1'b0, 16'hFDDB);
    step();
    applyStimulus(1'b0, 1'b1, 16'hE010);
    checkOutput("mid_bank_set", 32'(bus.ROM_SEL), 32'b1011);
    bus.DL_REQ = 1'b1;
    bus.CS0    = 1'b0;
    repeat (2) step();
    RESET = 1'b1;
    #1;
    checkOutput("midwait_sreset", 32'(SRESET), 32'd1);
    checkOutput("midwait_romsel", 32'(bus.ROM_SEL), 32'd0);
    checkOutput("midwait_we", 32'(bus.ROM_WE), 32'd0);
    checkOutput("midwait_ack", 32'(bus.DL_ACK), 32'd0);
    RESET   = 1'b0;
    bus.CS0 = 1'b1;
    step();
    checkOutput("midwr_we_before", 32'(bus.ROM_WE), 32'd1);
    RESET = 1'b1;
    #1;
    checkOutput("midwr_we_reset", 32'(bus.ROM_WE), 32'd0);
    RESET = 1'b0;
    repeat (2) step();
    checkOutput("midack_ack_before", 32'(bus.DL_ACK), 32'd1);
    RESET = 1'b1;
    #1;
    checkOutput("midack_ack_reset", 32'(bus.DL_ACK), 32'd0);
    checkOutput("midack_sreset", 32'(SRESET), 32'd1);
    bus.DL_REQ = 1'b0;
    RESET      = 1'b0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
